sync_fifo_ram: RTL and testbench
================================

Name: sync_fifo_ram

Overview:
- Single-clock synchronous FIFO built around an inferred dual-port memory array, parametrised in word width and depth.
- Adds behaviour the plain dual-port RAM lacks: internal pointer management, occupancy count, full/empty and programmable almost-full/almost-empty flags, and overflow/underflow error pulses.
- Intended as the standard buffering element between producer/consumer blocks sharing one clock domain.

Parameters:
- ADDR_BITS, 8, pointer width; depth DEPTH = 2**ADDR_BITS words.
- WORD_LENGTH, 8, data word width in bits.
- ALMOST_FULL_TH, 2**ADDR_BITS - 2, o_almost_full asserted when count >= this value; legal range 1..DEPTH.
- ALMOST_EMPTY_TH, 2, o_almost_empty asserted when count <= this value; legal range 0..DEPTH-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_write_en  input  1  write request for the current cycle.
- i_data  input  WORD_LENGTH  write data, sampled with i_write_en.
- i_read_en  input  1  read request for the current cycle.
- o_data  output  WORD_LENGTH  registered read data.
- o_valid  output  1  one-cycle pulse; o_data carries a newly read word.
- o_full  output  1  count == DEPTH.
- o_empty  output  1  count == 0.
- o_almost_full  output  1  count >= ALMOST_FULL_TH.
- o_almost_empty  output  1  count <= ALMOST_EMPTY_TH.
- o_count  output  ADDR_BITS+1  current occupancy, 0..DEPTH.
- o_overflow  output  1  one-cycle pulse; a write was rejected.
- o_underflow  output  1  one-cycle pulse; a read was rejected.

Behaviour:
- Reset (async assert, sync release): write/read pointers = 0; o_count = 0; o_empty = 1; o_almost_empty = 1; o_full = 0; o_almost_full = 0; o_data = 0; o_valid = 0; o_overflow = 0; o_underflow = 0.
- Memory contents are not reset.
- Write acceptance: wr_ok = i_write_en & ~o_full, using the registered flag.
  - On wr_ok: mem[wptr] <= i_data; wptr increments.
  - i_write_en while full: no memory or pointer change; o_overflow = 1 in the following cycle.
- Read acceptance: rd_ok = i_read_en & ~o_empty, using the registered flag.
  - On rd_ok: o_data <= mem[rptr]; rptr increments; o_valid = 1 in the following cycle.
  - Read latency is 1 clock; o_data holds its value when no read is accepted.
  - i_read_en while empty: no change; o_underflow = 1 in the following cycle.
- Pointers are ADDR_BITS wide and wrap naturally from DEPTH-1 to 0.
- o_count update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged when both or neither are accepted.
- All flags are registered and computed from the next-state count, so they are coherent with o_count in the same cycle.
- Simultaneous requests:
  - Both requests while empty: write accepted, read rejected (underflow pulse); count becomes 1.
  - Both requests while full: read accepted, write rejected (overflow pulse); count becomes DEPTH-1.
  - Both requests with 0 < count < DEPTH: both accepted; count unchanged. The read returns the oldest word, never the word written that cycle.
- Reset asserted mid-operation: all outputs take reset values immediately. In-flight data is discarded, and no o_valid pulse is produced for a read accepted in the cycle reset asserts.
- Ordering is strict FIFO; no data loss on accepted transactions.

Test Plan:
- Reset then idle: rst 1->0, no requests -> o_empty = 1, o_almost_empty = 1, o_count = 0, o_data = 0, no pulses.
- Fill/drain (ADDR_BITS = 3, WORD_LENGTH = 8): write 0x10..0x17 over 8 cycles -> o_full = 1, o_count = 8, o_almost_full from count 6. Then read 8 -> o_data = 0x10..0x17 in order, each one cycle after its read, with o_valid pulses; o_empty = 1 at end.
- Overflow/underflow: write 0xAA while full -> o_overflow pulse, count stays 8, subsequent reads return no 0xAA. Read while empty -> o_underflow pulse, o_valid stays 0.
- Simultaneous read+write at count 4 for 20 cycles -> count stays 4, pointers wrap past 7, output sequence matches the written order.
- Simultaneous read+write at empty and at full -> empty: count = 1 plus underflow pulse; full: count = 7 plus overflow pulse; data order preserved.
- Async reset mid-stream: assert rst between clock edges at count 5 -> o_count = 0 and o_empty = 1 before the next edge. A write of 0x55 after release is then read back as the first word.

Source files
------------

// File: rtl/sync_fifo_ram_if.sv
// Handshake bundle between a sync_fifo_ram and its producer/consumer.
// The FIFO takes the slave side; the surrounding logic takes the master side.
interface sync_fifo_ram_if #(
   parameter int unsigned ADDR_BITS   = 8,
   parameter int unsigned WORD_LENGTH = 8
);
   logic                   write_en;
   logic [WORD_LENGTH-1:0] wdata;
   logic                   read_en;
   logic [WORD_LENGTH-1:0] rdata;
   logic                   valid;
   logic                   full;
   logic                   empty;
   logic                   almost_full;
   logic                   almost_empty;
   logic [ADDR_BITS:0]     count;
   logic                   overflow;
   logic                   underflow;

   modport master (
      output write_en, wdata, read_en,
      input  rdata, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  write_en, wdata, read_en,
      output rdata, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO over an inferred dual-port array, with registered occupancy,
// full/empty, programmable almost-full/almost-empty flags and overflow/underflow pulses.
module sync_fifo_ram #(
   parameter int unsigned ADDR_BITS       = 8,
   parameter int unsigned WORD_LENGTH     = 8,
   parameter int unsigned ALMOST_FULL_TH  = 2**ADDR_BITS - 2,
   parameter int unsigned ALMOST_EMPTY_TH = 2
) (
   input logic              clk,
   input logic              rst,
   sync_fifo_ram_if.slave   bus
);
   localparam int unsigned Depth = 2**ADDR_BITS;
   localparam logic [ADDR_BITS:0] DepthC = (ADDR_BITS+1)'(Depth);
   localparam logic [ADDR_BITS:0] AfTh   = (ADDR_BITS+1)'(ALMOST_FULL_TH);
   localparam logic [ADDR_BITS:0] AeTh   = (ADDR_BITS+1)'(ALMOST_EMPTY_TH);

   logic [WORD_LENGTH-1:0] mem [Depth];

   logic [ADDR_BITS-1:0]   wptr_q, rptr_q;
   logic [ADDR_BITS:0]     count_q, count_d;
   logic [WORD_LENGTH-1:0] data_q;
   logic                   valid_q, full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
   logic                   wr_ok, rd_ok;

   // Acceptance uses the registered flags, so a full FIFO can still take a write
   // only in the cycle after a read has made room.
   assign wr_ok = bus.write_en & ~full_q;
   assign rd_ok = bus.read_en & ~empty_q;

   always_comb begin
      count_d = count_q;
      if (wr_ok && !rd_ok) begin
         count_d = count_q + 1'b1;
      end else if (rd_ok && !wr_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wptr_q] <= bus.wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         af_q    <= 1'b0;
         ae_q    <= 1'b1;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         if (wr_ok) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (rd_ok) begin
            data_q <= mem[rptr_q];
            rptr_q <= rptr_q + 1'b1;
         end
         count_q <= count_d;
         valid_q <= rd_ok;
         ovf_q   <= bus.write_en & ~wr_ok;
         udf_q   <= bus.read_en & ~rd_ok;
         full_q  <= (count_d == DepthC);
         empty_q <= (count_d == '0);
         af_q    <= (count_d >= AfTh);
         ae_q    <= (count_d <= AeTh);
      end
   end

   assign bus.rdata        = data_q;
   assign bus.valid        = valid_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = af_q;
   assign bus.almost_empty = ae_q;
   assign bus.count        = count_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_ram.sv
// Self-checking bench for sync_fifo_ram: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_sync_fifo_ram;
   localparam int unsigned AB    = 3;
   localparam int unsigned WL    = 8;
   localparam int unsigned DEPTH = 2**AB;
   localparam int unsigned AF_TH = DEPTH - 2;
   localparam int unsigned AE_TH = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   compared   = 0;
   int   mismatched = 0;

   logic [WL-1:0] model_q[$];
   logic [WL-1:0] exp_data  = '0;
   logic          exp_valid = 1'b0;
   logic          exp_ovf   = 1'b0;
   logic          exp_udf   = 1'b0;

   sync_fifo_ram_if #(.ADDR_BITS(AB), .WORD_LENGTH(WL)) bus ();

   sync_fifo_ram #(
      .ADDR_BITS      (AB),
      .WORD_LENGTH    (WL),
      .ALMOST_FULL_TH (AF_TH),
      .ALMOST_EMPTY_TH(AE_TH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string ph);
      int n;
      n = model_q.size();
      check({ph, ":count"},    32'(bus.count), 32'(n));
      check({ph, ":full"},     32'(bus.full), 32'(n == DEPTH));
      check({ph, ":empty"},    32'(bus.empty), 32'(n == 0));
      check({ph, ":afull"},    32'(bus.almost_full), 32'(n >= AF_TH));
      check({ph, ":aempty"},   32'(bus.almost_empty), 32'(n <= AE_TH));
      check({ph, ":valid"},    32'(bus.valid), 32'(exp_valid));
      check({ph, ":data"},     32'(bus.rdata), 32'(exp_data));
      check({ph, ":overflow"}, 32'(bus.overflow), 32'(exp_ovf));
      check({ph, ":underflow"}, 32'(bus.underflow), 32'(exp_udf));
   endtask

   // Drive one cycle of requests, update the model from the pre-edge occupancy,
   // then compare 1 time unit after the rising edge.
   task automatic step(input string ph, input logic we, input logic [WL-1:0] d, input logic re);
      bit wr_ok, rd_ok;
      bus.write_en = we;
      bus.wdata    = d;
      bus.read_en  = re;
      wr_ok = we && (model_q.size() < DEPTH);
      rd_ok = re && (model_q.size() > 0);
      @(posedge clk);
      #1;
      if (rd_ok) exp_data = model_q.pop_front();
      if (wr_ok) model_q.push_back(d);
      exp_valid = rd_ok;
      exp_ovf   = we && !wr_ok;
      exp_udf   = re && !rd_ok;
      bus.write_en = 1'b0;
      bus.read_en  = 1'b0;
      check_all(ph);
   endtask

   initial begin
      bus.write_en = 1'b0;
      bus.read_en  = 1'b0;
      bus.wdata    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_all("reset");
      repeat (3) step("idle", 1'b0, '0, 1'b0);

      for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, WL'(8'h10 + i), 1'b0);
      step("ovf", 1'b1, 8'hAA, 1'b0);
      for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, '0, 1'b1);
      step("udf", 1'b0, '0, 1'b1);

      step("both_empty", 1'b1, 8'h21, 1'b1);
      for (int i = 0; i < 3; i++) step("to4", 1'b1, WL'(8'h22 + i), 1'b0);
      for (int i = 0; i < 20; i++) step("both4", 1'b1, WL'(8'h30 + i), 1'b1);
      for (int i = 0; i < 4; i++) step("to8", 1'b1, WL'(8'h50 + i), 1'b0);
      step("both_full", 1'b1, 8'hBB, 1'b1);
      for (int i = 0; i < 7; i++) step("drain2", 1'b0, '0, 1'b1);

      for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, WL'(8'h60 + i), 1'b0);
      // Raise reset between edges with a read pending; outputs must clear at once.
      bus.read_en = 1'b1;
      #2 rst = 1'b1;
      #1;
      model_q.delete();
      exp_data = '0; exp_valid = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
      check_all("async_rst");
      @(posedge clk);
      #1 check_all("in_rst");
      bus.read_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step("post_rst_wr", 1'b1, 8'h55, 1'b0);
      step("post_rst_rd", 1'b0, '0, 1'b1);

      for (int i = 0; i < 400; i++) begin
         int bias;
         bias = (i / 100) % 2 == 0 ? 70 : 30;
         step("rand", ($urandom_range(99) < bias), WL'($urandom), ($urandom_range(99) < 100 - bias));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
